clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, default 16: width of the divisor and phase counter.
REQ-002 Parameter DIV_DEFAULT, default 4: divisor active after reset; SHALL be >= 2 and < 2**WIDTH.
REQ-003 Port clk_in, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port en, input, 1: run request; level-sensitive.
REQ-006 Port div_wr, input, 1: one-cycle strobe requesting a new divisor.
REQ-007 Port div_in, input, WIDTH: divisor value, sampled when div_wr=1.
REQ-008 Port div_busy, output, 1: high while a divisor is pending and not yet applied.
REQ-009 Port div_err, output, 1: one-cycle pulse when div_wr carries an illegal value (div_in < 2).
REQ-010 Port clk_out, output, 1: registered divided clock.
REQ-011 Port tick, output, 1: one-cycle strobe, high in the same cycle that clk_out goes from 0 to 1.
REQ-012 Port div_cur, output, WIDTH: divisor that governs the current period.

Function
REQ-013 The FSM SHALL have 3 states: IDLE, HIGH, LOW.
REQ-014 Divisor D: HIGH SHALL last H = D - floor(D/2) cycles; LOW SHALL last L = floor(D/2) cycles; period = D clk_in cycles. For odd D, high is longer by one cycle.
REQ-015 In IDLE, clk_out=0 and tick=0. When en=1, the block SHALL enter HIGH on the next edge, with clk_out=1 and tick=1 on that same edge.
REQ-016 HIGH->LOW SHALL occur after H cycles, with clk_out=0.
REQ-017 At the end of LOW with en=1, the block SHALL re-enter HIGH and pulse tick. With en=0, it SHALL enter IDLE.
REQ-018 Stop SHALL be glitch-free: deasserting en mid-period completes the current HIGH and LOW phases in full.
REQ-019 A legal div_wr SHALL load a pending register and set div_busy on the next edge. The pending value SHALL be applied to div_cur only on a transition into HIGH from LOW or IDLE. div_busy SHALL clear on that same edge.
REQ-020 div_wr while div_busy=1 SHALL overwrite the pending value; last write wins, and no error is raised.
REQ-021 Illegal div_wr (div_in 0 or 1) SHALL leave the pending value and div_busy unchanged and pulse div_err for one cycle.
REQ-022 A legal div_wr in the same cycle as a transition into HIGH SHALL NOT apply to that period; it takes effect at the next period start.
REQ-023 A divisor change SHALL NOT truncate or extend the phase in progress; no runt pulses are allowed.
REQ-024 The phase counter SHALL be WIDTH bits, count 0..(phase length - 1), and never wrap past 2**WIDTH-1.
REQ-025 div_cur SHALL equal the D used for the period currently being output. In IDLE it holds the last applied value.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state IDLE, counter 0, clk_out 0, tick 0, div_err 0, div_busy 0, div_cur DIV_DEFAULT, pending DIV_DEFAULT.
REQ-027 Reset mid-period SHALL drop clk_out low immediately. After release, the first period SHALL use DIV_DEFAULT, and operation resumes per REQ-015 once en=1.
REQ-028 Reset deassertion SHALL be honoured on the first clk_in edge after release; no extra synchroniser is in scope.

Structure
REQ-029 A shared package SHALL hold the state enumeration (IDLE, HIGH, LOW) and the constant DIV_MIN = 2.
REQ-030 One sub-module is natural: clk_div_phase_cnt, a loadable down-counter with a terminal-count output, instantiated once.
REQ-031 There SHALL be no combinational path from any input to clk_out or tick.

Verification
REQ-032 D=4 default, en=1 after reset: clk_out pattern 1,1,0,0 repeating; tick every 4th cycle; div_cur=4.
REQ-033 div_wr with div_in=5 mid-HIGH of a D=4 period: the current period stays 2H/2L; the next period is 3H/2L; div_busy is high from the write until that next rise.
REQ-034 div_in=1: div_err pulses for 1 cycle; div_busy and div_cur are unchanged; the output continues at D=4.
REQ-035 en dropped on the first HIGH cycle at D=6: 3 HIGH then 3 LOW cycles complete, then IDLE with clk_out=0 and no further tick.
REQ-036 Back-to-back div_wr 7 then 9 within one period: the next period uses 9 (5H/4L); 7 is never output.
REQ-037 rst_n pulsed low during LOW at D=9: clk_out=0 at once; after release with en=1, the first period is DIV_DEFAULT (2H/2L).

Source files
------------

// File: rtl/clk_div_prog_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_prog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_e;

  localparam int unsigned DIV_MIN = 32'd2;

endpackage

// File: rtl/clk_div_prog_phase_cnt.sv
// Loadable down-counter that times one output phase; tc is high when the count is zero.
module clk_div_phase_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_r;

  // Phase counter: load on phase start, otherwise count down and hold at zero.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: IDLE/HIGH/LOW FSM with a pending divisor applied only at period start.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_in,
  output logic             div_busy,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] DIV_MIN_W = WIDTH'(DIV_MIN);
  localparam logic [WIDTH-1:0] DIV_RST_W = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(32'd1);

  state_e           state_r;
  logic [WIDTH-1:0] pend_r;
  logic [WIDTH-1:0] div_cur_r;
  logic             busy_r;
  logic             err_r;
  logic             clk_out_r;
  logic             tick_r;

  logic             tc_s;
  logic             load_s;
  logic [WIDTH-1:0] load_val_s;
  logic             start_s;
  logic             wr_ok_s;

  // Counter preload values are length-1 since the counter runs down to zero inclusive.
  function automatic logic [WIDTH-1:0] high_m1(input logic [WIDTH-1:0] d);
    return d - (d >> 1) - ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] low_m1(input logic [WIDTH-1:0] d);
    return (d >> 1) - ONE_W;
  endfunction

  // Next-phase decode: period start uses the pending divisor, LOW uses the applied one.
  always_comb begin
    wr_ok_s    = div_wr && (div_in >= DIV_MIN_W);
    start_s    = 1'b0;
    load_s     = 1'b0;
    load_val_s = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (en) begin
          start_s    = 1'b1;
          load_s     = 1'b1;
          load_val_s = high_m1(pend_r);
        end else begin
          start_s    = 1'b0;
        end
      end
      HIGH: begin
        if (tc_s) begin
          load_s     = 1'b1;
          load_val_s = low_m1(div_cur_r);
        end else begin
          load_s     = 1'b0;
        end
      end
      LOW: begin
        if (tc_s && en) begin
          start_s    = 1'b1;
          load_s     = 1'b1;
          load_val_s = high_m1(pend_r);
        end else begin
          start_s    = 1'b0;
        end
      end
      default: begin
        start_s    = 1'b0;
        load_s     = 1'b0;
      end
    endcase
  end

  clk_div_phase_cnt #(
    .WIDTH (WIDTH)
  ) u_phase_cnt (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (load_val_s),
    .tc       (tc_s)
  );

  // Output FSM: clk_out and tick are registered from the state transition.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      tick_r <= start_s;
      case (state_r)
        IDLE: begin
          if (en) begin
            state_r   <= HIGH;
            clk_out_r <= 1'b1;
          end else begin
            state_r   <= IDLE;
            clk_out_r <= 1'b0;
          end
        end
        HIGH: begin
          if (tc_s) begin
            state_r   <= LOW;
            clk_out_r <= 1'b0;
          end else begin
            state_r   <= HIGH;
            clk_out_r <= 1'b1;
          end
        end
        LOW: begin
          if (tc_s && en) begin
            state_r   <= HIGH;
            clk_out_r <= 1'b1;
          end else if (tc_s) begin
            state_r   <= IDLE;
            clk_out_r <= 1'b0;
          end else begin
            state_r   <= LOW;
            clk_out_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          clk_out_r <= 1'b0;
        end
      endcase
    end
  end

  // Divisor handling: a write landing on a period start is held for the following period.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_r    <= DIV_RST_W;
      div_cur_r <= DIV_RST_W;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= div_wr && !wr_ok_s;
      if (start_s) begin
        div_cur_r <= pend_r;
      end else begin
        div_cur_r <= div_cur_r;
      end
      if (wr_ok_s) begin
        pend_r <= div_in;
        busy_r <= 1'b1;
      end else if (start_s) begin
        pend_r <= pend_r;
        busy_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
        busy_r <= busy_r;
      end
    end
  end

  assign clk_out  = clk_out_r;
  assign tick     = tick_r;
  assign div_busy = busy_r;
  assign div_err  = err_r;
  assign div_cur  = div_cur_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog; expected waveforms are hand-derived per scenario.
module tb_clk_div_prog;

  localparam int WIDTH = 16;

  logic             clk_in;
  logic             rst_n;
  logic             en;
  logic             div_wr;
  logic [WIDTH-1:0] div_in;
  logic             div_busy;
  logic             div_err;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_cur;

  int checks;
  int errors;

  clk_div_prog #(
    .WIDTH       (WIDTH),
    .DIV_DEFAULT (4)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .div_busy (div_busy),
    .div_err  (div_err),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Outputs observed as {clk_out, tick, div_busy, div_err}.
  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    div_wr = 1'b0;
    div_in = 16'd0;
    step();
    step();
    checks++;
    if ({clk_out, tick, div_busy, div_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000", {clk_out, tick, div_busy, div_err});
    end
    checks++;
    if (div_cur !== 16'd4) begin
      errors++;
      $display("FAIL reset_div_cur got %0d want 4", div_cur);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_default();
    logic [3:0] exp_v [8];
    exp_v = '{4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({clk_out, tick, div_busy, div_err} !== exp_v[i]) begin
        errors++;
        $display("FAIL default_cyc%0d got %b want %b", i, {clk_out, tick, div_busy, div_err}, exp_v[i]);
      end
      checks++;
      if (div_cur !== 16'd4) begin
        errors++;
        $display("FAIL default_div_cur%0d got %0d want 4", i, div_cur);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] exp_v [5];
    exp_v = '{4'b1101, 4'b1000, 4'b0000, 4'b0000, 4'b1100};
    div_wr = 1'b1;
    div_in = 16'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      div_wr = 1'b0;
      checks++;
      if ({clk_out, tick, div_busy, div_err} !== exp_v[i]) begin
        errors++;
        $display("FAIL illegal_cyc%0d got %b want %b", i, {clk_out, tick, div_busy, div_err}, exp_v[i]);
      end
      checks++;
      if (div_cur !== 16'd4) begin
        errors++;
        $display("FAIL illegal_div_cur%0d got %0d want 4", i, div_cur);
      end
    end
  endtask

  // Entered on the first HIGH cycle of a D=4 period.
  task automatic test_change();
    logic [3:0]       exp_v [9];
    logic [WIDTH-1:0] exp_d [9];
    exp_v = '{4'b1010, 4'b0010, 4'b0010, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1100};
    exp_d = '{16'd4, 16'd4, 16'd4, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
    div_wr = 1'b1;
    div_in = 16'd5;
    for (int i = 0; i < 9; i++) begin
      step();
      div_wr = 1'b0;
      checks++;
      if ({clk_out, tick, div_busy, div_err} !== exp_v[i]) begin
        errors++;
        $display("FAIL change_cyc%0d got %b want %b", i, {clk_out, tick, div_busy, div_err}, exp_v[i]);
      end
      checks++;
      if (div_cur !== exp_d[i]) begin
        errors++;
        $display("FAIL change_div_cur%0d got %0d want %0d", i, div_cur, exp_d[i]);
      end
    end
  endtask

  // Entered on the first HIGH cycle of a D=5 period.
  task automatic test_stop();
    logic [3:0] exp_v [10];
    int         waited;
    exp_v = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    div_wr = 1'b1;
    div_in = 16'd6;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      div_wr = 1'b0;
      waited++;
      if (tick === 1'b1) break;
    end
    checks++;
    if (waited !== 5) begin
      errors++;
      $display("FAIL stop_wait_tick got %0d cycles want 5", waited);
    end
    checks++;
    if (div_cur !== 16'd6) begin
      errors++;
      $display("FAIL stop_div_cur got %0d want 6", div_cur);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({clk_out, tick, div_busy, div_err} !== exp_v[i]) begin
        errors++;
        $display("FAIL stop_cyc%0d got %b want %b", i, {clk_out, tick, div_busy, div_err}, exp_v[i]);
      end
    end
    checks++;
    if (div_cur !== 16'd6) begin
      errors++;
      $display("FAIL stop_idle_div_cur got %0d want 6", div_cur);
    end
  endtask

  // Entered in IDLE with D=6 applied.
  task automatic test_back_to_back();
    logic [3:0]       exp_v [16];
    logic [WIDTH-1:0] exp_d [16];
    exp_v = '{4'b1100, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010, 4'b1100, 4'b1000,
              4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100};
    exp_d = '{16'd6, 16'd6, 16'd6, 16'd6, 16'd6, 16'd6, 16'd9, 16'd9,
              16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9};
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 1) begin
        div_wr = 1'b1;
        div_in = 16'd7;
      end else if (i == 2) begin
        div_in = 16'd9;
      end else begin
        div_wr = 1'b0;
      end
      step();
      checks++;
      if ({clk_out, tick, div_busy, div_err} !== exp_v[i]) begin
        errors++;
        $display("FAIL b2b_cyc%0d got %b want %b", i, {clk_out, tick, div_busy, div_err}, exp_v[i]);
      end
      checks++;
      if (div_cur !== exp_d[i]) begin
        errors++;
        $display("FAIL b2b_div_cur%0d got %0d want %0d", i, div_cur, exp_d[i]);
      end
    end
    div_wr = 1'b0;
  endtask

  // Entered on the first HIGH cycle of a D=9 period.
  task automatic test_reset_mid();
    logic [3:0] exp_v [5];
    exp_v = '{4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b1100};
    for (int i = 0; i < 5; i++) begin
      step();
    end
    checks++;
    if (clk_out !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_in_low got %b want 0", clk_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, div_busy, div_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async got %b want 0000", {clk_out, tick, div_busy, div_err});
    end
    checks++;
    if (div_cur !== 16'd4) begin
      errors++;
      $display("FAIL rstmid_div_cur got %0d want 4", div_cur);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({clk_out, tick, div_busy, div_err} !== exp_v[i]) begin
        errors++;
        $display("FAIL rstmid_cyc%0d got %b want %b", i, {clk_out, tick, div_busy, div_err}, exp_v[i]);
      end
      checks++;
      if (div_cur !== 16'd4) begin
        errors++;
        $display("FAIL rstmid_post_div_cur%0d got %0d want 4", i, div_cur);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_default();
    test_illegal();
    test_change();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
